factorial_bus_if: RTL and testbench
===================================

Name: factorial_bus_if

Overview:
- Memory-mapped register front end for the factorial accelerator. It sits between the MIPS data-memory bus and the factorial core (control FSM plus datapath).
- Latches the operand n and issues a start pulse to the core.
- Tracks the core's busy/done/err behaviour and captures the product into a readable result register.
- Software launches a job with a GO write and polls STATUS.

Parameters:
- DATA_W, 32, width of bus data and of the result.
- N_W, 4, width of operand n passed to the core.
- START_TO, 8, cycles allowed after the go pulse for the core to drop done_in. If it does not, the launch is treated as rejected.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- we  in  1  bus write enable.
- addr  in  2  word address (byte address bits [3:2]).
- wd  in  DATA_W  bus write data.
- rd  out  DATA_W  bus read data, combinational from addr.
- n_out  out  N_W  operand to the core.
- go_out  out  1  start pulse to the core.
- done_in  in  1  core done; high while the core is idle.
- err_in  in  1  core operand error; n too large for DATA_W.
- result_in  in  DATA_W  core product output.
- busy  out  1  high while a job is in flight.

Behaviour:
- Register map:
  - 0 = N (RW): bits [N_W-1:0], upper bits read 0.
  - 1 = GO (W): bit0=1 launches; reads 0.
  - 2 = STATUS (R): {.., err_s, done_s} at bits [1:0].
  - 3 = RESULT (R): result_r.
- Reset: n_r=0, go_out=0, busy=0, done_s=0, err_s=0, result_r=0, cnt=0, state=IDLE. Reset mid-job aborts immediately, and go_out drops the same instant.
- Writes to N: accepted in IDLE only; ignored while busy.
- State machine:
  - IDLE:
    - A GO write with wd[0]=1 sets go_out=1 for exactly one clk cycle and clears done_s and err_s.
    - It also sets busy=1, sets cnt=0, and moves to LAUNCH.
    - A GO write with wd[0]=0 is a no-op.
  - LAUNCH:
    - go_out=0. Wait for done_in=0.
    - If done_in=0: move to RUN.
    - Otherwise cnt++. When cnt==START_TO-1 and done_in is still 1, set err_s=1 and done_s=1, clear busy, and return to IDLE.
    - err_in=1 sampled while in LAUNCH forces the same reject path immediately.
  - RUN:
    - Wait for done_in=1.
    - On the first cycle it is high: result_r<=result_in, done_s<=1, busy<=0, move to IDLE.
- Rules for writes and events:
  - A GO write while busy is ignored; no second pulse.
  - A simultaneous N write and GO write is impossible (single address).
  - A GO write in the same cycle that RUN completes is ignored, because busy is still 1 in that cycle.
- Status bits: done_s and err_s are sticky until the next accepted GO or reset. result_r holds its value across rejected launches.
- Width: n_out = n_r. result_in is captured unmodified, with no truncation logic in this block.
- Launch latency: go_out is asserted one posedge after the GO write edge, and is never asserted for more than 1 cycle.

Test Plan:
- Reset with rst asserted mid-RUN → all outputs 0 asynchronously, state IDLE; the next GO launches normally.
- Write N=5, write GO=1, core model drops done_in for 10 cycles then raises it with result_in=120 → exactly one go_out pulse; busy high throughout; RESULT=120; STATUS=01.
- Write N=13 (DATA_W=32 overflow) with the core holding err_in=1 and done_in=1 → STATUS=11, busy low within ≤START_TO cycles, RESULT unchanged.
- Core never drops done_in after go (no err) → reject at exactly START_TO cycles after LAUNCH entry; STATUS=11.
- During RUN, write N=3 and write GO=1 → n_out stays 5; no extra go_out pulse. After completion, GO launches with n_out=5 until N is rewritten.
- Back-to-back: N=0 (expected result 1) then N=1 (expected result 1) → done_s is cleared on the second GO and set again; each RESULT is captured correctly.

Source files
------------

// File: rtl/factorial_bus_if.sv
// -----------------------------------------------------------------------------
// factorial_bus_if
//
// Memory-mapped register front end for the factorial accelerator. It sits
// between the MIPS data-memory bus and the factorial core. Software writes the
// operand N, launches a job with a GO write, then polls STATUS and reads RESULT.
//
// Register map (word address = byte address bits [3:2]):
//   0 N      (RW) bits [N_W-1:0], upper bits read 0; writable only while idle
//   1 GO     (W)  bit0=1 launches a job; reads 0
//   2 STATUS (R)  {.., err_s, done_s} in bits [1:0]; sticky until next launch
//   3 RESULT (R)  product captured from the core on job completion
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous, active-high reset
//   we         bus write enable
//   addr       word address
//   wd         bus write data
//   rd         bus read data, combinational from addr
//   n_out      operand to the core
//   go_out     one-cycle start pulse to the core
//   done_in    core done; high while the core is idle
//   err_in     core operand error (n too large for DATA_W)
//   result_in  core product
//   busy       high while a job is in flight
// -----------------------------------------------------------------------------
module factorial_bus_if #(
    parameter int DATA_W   = 32,
    parameter int N_W      = 4,
    parameter int START_TO = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic [N_W-1:0]    n_out,
    output logic              go_out,
    input  logic              done_in,
    input  logic              err_in,
    input  logic [DATA_W-1:0] result_in,
    output logic              busy
);

    localparam int               CNT_W    = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,  // go pulse issued, waiting for the core to drop done_in
        RUN    = 2'd2   // core computing, waiting for done_in to return high
    } state_t;

    state_t             state, state_d;
    logic [N_W-1:0]     n_r, n_d;
    logic               go_d;
    logic               done_s, done_d;
    logic               err_s, err_d;
    logic [DATA_W-1:0]  result_r, result_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    // Only the operand bits of a write are meaningful; the rest are dropped.
    logic unused_wd;
    assign unused_wd = ^wd[DATA_W-1:N_W];

    // -------------------------------------------------------------------------
    // State and register file
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_r      <= '0;
            go_out   <= 1'b0;
            done_s   <= 1'b0;
            err_s    <= 1'b0;
            result_r <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_d;
            n_r      <= n_d;
            go_out   <= go_d;
            done_s   <= done_d;
            err_s    <= err_d;
            result_r <= result_d;
            cnt      <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and register update logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state;
        n_d      = n_r;
        go_d     = 1'b0;
        done_d   = done_s;
        err_d    = err_s;
        result_d = result_r;
        cnt_d    = cnt;

        unique case (state)
            IDLE: begin
                if (we && addr == A_N) begin
                    n_d = wd[N_W-1:0];
                end
                if (we && addr == A_GO && wd[0]) begin
                    go_d    = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LAUNCH;
                end
            end

            LAUNCH: begin
                // An operand error or a core that never acknowledges the go
                // pulse both end the job as rejected, leaving result_r intact.
                if (err_in) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!done_in) begin
                    state_d = RUN;
                end else if (cnt == CNT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            RUN: begin
                if (done_in) begin
                    result_d = result_in;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy  = (state != IDLE);
    assign n_out = n_r;

    always_comb begin
        rd = '0;
        unique case (addr)
            A_N:      rd = {{(DATA_W-N_W){1'b0}}, n_r};
            A_GO:     rd = '0;
            A_STATUS: rd = {{(DATA_W-2){1'b0}}, err_s, done_s};
            A_RESULT: rd = result_r;
            default:  rd = '0;
        endcase
    end

endmodule

// File: tb/tb_factorial_bus_if.sv
// -----------------------------------------------------------------------------
// tb_factorial_bus_if
//
// Self-checking bench for factorial_bus_if. A small behavioural core drives
// done_in/result_in; the reference model tracks the operand, the last captured
// result and the expected job outcome (completion, operand error, or launch
// timeout) from the register-level rules, using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_factorial_bus_if;

    localparam int DATA_W   = 32;
    localparam int N_W      = 4;
    localparam int START_TO = 8;

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    localparam int MODE_RUN   = 0;
    localparam int MODE_ERR   = 1;
    localparam int MODE_STUCK = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic [N_W-1:0]    n_out;
    logic              go_out;
    logic              done_in;
    logic              err_in;
    logic [DATA_W-1:0] result_in;
    logic              busy;

    factorial_bus_if #(
        .DATA_W   (DATA_W),
        .N_W      (N_W),
        .START_TO (START_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd),
        .n_out     (n_out),
        .go_out    (go_out),
        .done_in   (done_in),
        .err_in    (err_in),
        .result_in (result_in),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Core emulation controls (written by the stimulus process only).
    logic core_hold = 1'b0;   // core ignores go and keeps done_in high
    int   core_run  = 10;     // cycles done_in stays low during a job

    // Reference model state.
    int unsigned model_n      = 0;
    logic [31:0] model_result = 32'd0;

    // go_out pulse monitor.
    int   go_count  = 0;
    int   go_double = 0;
    logic go_prev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] fact(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    always @(negedge clk) begin
        if (go_out === 1'b1) go_count++;
        if (go_out === 1'b1 && go_prev === 1'b1) go_double++;
        go_prev = go_out;
    end

    // Behavioural core: on a go pulse, drop done_in for core_run cycles with
    // junk on result_in, then present n_out! and raise done_in again.
    initial begin
        done_in   = 1'b1;
        result_in = '0;
        forever begin
            @(negedge clk);
            if (go_out === 1'b1 && rst === 1'b0) begin
                if (core_hold) begin
                    result_in = $urandom();
                end else begin
                    done_in   = 1'b0;
                    result_in = $urandom();
                    repeat (core_run) @(negedge clk);
                    result_in = fact(n_out);
                    done_in   = 1'b1;
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts samples with busy high (one per cycle) until it drops; bounded.
    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 400) begin
            cycles++;
            next_cycle();
        end
        check({tag, "/busy_drop"}, busy, 0);
    endtask

    task automatic run_job(input string tag, input int unsigned n, input int mode, input int run_len);
        int          cyc;
        int          go0;
        int          exp_cyc;
        logic [31:0] exp_status;
        logic [31:0] v;
        bus_write(A_N, ($urandom() & 32'hFFFF_FFF0) | 32'(n));
        model_n = n;
        bus_read(A_N, v);
        check({tag, "/n_reg"}, v, model_n);
        core_run  = run_len;
        core_hold = (mode != MODE_RUN);
        err_in    = (mode == MODE_ERR);
        go0       = go_count;
        bus_write(A_GO, $urandom() | 32'd1);
        check({tag, "/go_out"}, go_out, 1);
        bus_read(A_STATUS, v);
        check({tag, "/status_clr"}, v, 0);
        wait_idle(tag, cyc);
        if (mode == MODE_RUN) begin
            exp_cyc      = run_len + 1;
            exp_status   = 32'd1;
            model_result = fact(model_n);
        end else if (mode == MODE_ERR) begin
            exp_cyc    = 1;
            exp_status = 32'd3;
        end else begin
            exp_cyc    = START_TO;
            exp_status = 32'd3;
        end
        check({tag, "/busy_cycles"}, cyc, exp_cyc);
        bus_read(A_STATUS, v);
        check({tag, "/status"}, v, exp_status);
        bus_read(A_RESULT, v);
        check({tag, "/result"}, v, model_result);
        check({tag, "/n_out"}, n_out, model_n);
        check({tag, "/go_pulses"}, go_count - go0, 1);
        err_in    = 1'b0;
        core_hold = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int          go0;
        int          cyc;
        int unsigned rn;
        int          rmode;

        rst    = 1'b1;
        we     = 1'b0;
        addr   = A_N;
        wd     = '0;
        err_in = 1'b0;

        // Power-on reset state.
        repeat (3) @(posedge clk);
        #3;
        check("rst/busy", busy, 0);
        check("rst/go_out", go_out, 0);
        check("rst/n_out", n_out, 0);
        bus_read(A_STATUS, v);
        check("rst/status", v, 0);
        bus_read(A_RESULT, v);
        check("rst/result", v, 0);
        rst = 1'b0;
        next_cycle();

        // GO with bit0 clear is a no-op; GO reads as zero.
        go0 = go_count;
        bus_write(A_GO, 32'hFFFF_FFFE);
        check("go0/busy", busy, 0);
        next_cycle();
        check("go0/pulses", go_count - go0, 0);
        bus_read(A_GO, v);
        check("go0/read", v, 0);

        // Normal job, operand error, launch timeout.
        run_job("n5", 5, MODE_RUN, 10);
        run_job("n13_err", 13, MODE_ERR, 10);
        run_job("stuck", 4, MODE_STUCK, 10);

        // Writes to N and GO during RUN are ignored.
        bus_write(A_N, 32'd5);
        model_n  = 5;
        core_run = 10;
        go0      = go_count;
        bus_write(A_GO, 32'd1);
        next_cycle();
        next_cycle();
        check("midrun/busy", busy, 1);
        bus_write(A_N, 32'd3);
        bus_write(A_GO, 32'd1);
        check("midrun/n_out", n_out, 5);
        bus_read(A_N, v);
        check("midrun/n_reg", v, 5);
        wait_idle("midrun", cyc);
        check("midrun/pulses", go_count - go0, 1);
        model_result = fact(model_n);
        bus_read(A_RESULT, v);
        check("midrun/result", v, model_result);
        bus_read(A_STATUS, v);
        check("midrun/status", v, 1);

        // Relaunch without rewriting N reuses the held operand.
        go0 = go_count;
        bus_write(A_GO, 32'd1);
        wait_idle("relaunch", cyc);
        check("relaunch/n_out", n_out, model_n);
        check("relaunch/pulses", go_count - go0, 1);
        bus_read(A_RESULT, v);
        check("relaunch/result", v, fact(model_n));

        // GO landing on the completion edge of RUN is ignored.
        core_run = 4;
        go0      = go_count;
        bus_write(A_GO, 32'd1);
        repeat (4) next_cycle();
        check("coinc/busy_before", busy, 1);
        bus_write(A_GO, 32'd1);
        check("coinc/busy_after", busy, 0);
        repeat (3) next_cycle();
        check("coinc/busy_later", busy, 0);
        check("coinc/pulses", go_count - go0, 1);
        bus_read(A_STATUS, v);
        check("coinc/status", v, 1);

        // Back-to-back 0! and 1!.
        run_job("b2b_n0", 0, MODE_RUN, 3);
        run_job("b2b_n1", 1, MODE_RUN, 2);

        // Reset in the middle of RUN.
        bus_write(A_N, 32'd7);
        core_run = 10;
        bus_write(A_GO, 32'd1);
        repeat (3) next_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("rstrun/busy", busy, 0);
        check("rstrun/go_out", go_out, 0);
        check("rstrun/n_out", n_out, 0);
        bus_read(A_STATUS, v);
        check("rstrun/status", v, 0);
        bus_read(A_RESULT, v);
        check("rstrun/result", v, 0);
        rst          = 1'b0;
        model_n      = 0;
        model_result = 32'd0;
        for (int i = 0; i < 40 && done_in !== 1'b1; i++) next_cycle();
        check("rstrun/core_idle", done_in, 1);
        run_job("after_rst", 6, MODE_RUN, 5);

        // Reset while go_out is high kills the pulse at once.
        bus_write(A_N, 32'd3);
        go0 = go_count;
        bus_write(A_GO, 32'd1);
        check("rstgo/go_before", go_out, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rstgo/go_after", go_out, 0);
        check("rstgo/busy", busy, 0);
        #2;
        rst          = 1'b0;
        model_n      = 0;
        model_result = 32'd0;
        repeat (3) next_cycle();
        check("rstgo/pulses", go_count - go0, 0);
        check("rstgo/core_idle", done_in, 1);

        // Randomised jobs: operands above 12 overflow 32 bits and make the
        // core flag an error; otherwise the core occasionally never responds.
        for (int j = 0; j < 25; j++) begin
            rn = $urandom_range(15, 0);
            if (rn > 12) rmode = MODE_ERR;
            else if ($urandom_range(5, 0) == 0) rmode = MODE_STUCK;
            else rmode = MODE_RUN;
            run_job($sformatf("rnd%0d", j), rn, rmode, int'($urandom_range(15, 1)));
        end

        check("go_single_cycle", go_double, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
